// File: rtl/spi_frame_counter_pkg.sv
// Shared definitions for the SPI bit/word/frame sequencer.
package spi_frame_counter_pkg;

    localparam int DEF_MAX_WORD_LEN = 32;
    localparam int DEF_MAX_WORDS    = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/spi_frame_counter_bit_cnt.sv
// Bit position counter: wraps at the latched word length and strobes on the wrap.
module spi_bit_cnt #(
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             adv_i,
    input  logic [LEN_W-1:0] len_m1_i,
    output logic [LEN_W-1:0] cnt_o,
    output logic             wrap_o
);

    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;
    logic             at_end;

    assign at_end = (cnt_q == len_m1_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (adv_i) begin
            cnt_d = at_end ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = adv_i & ~clr_i & at_end;

endmodule

// File: rtl/spi_frame_counter.sv
// SPI master sequencer: counts SCLK sampling edges into words and frames,
// supplies the shifter bit index and word/frame completion pulses.
//   state   | meaning
//   ST_IDLE | no frame; edges ignored, waiting for Start with EnCount
//   ST_RUN  | frame in progress; edges advance bit/word counters
module spi_frame_counter
    import spi_frame_counter_pkg::*;
#(
    parameter  int MAX_WORD_LEN = DEF_MAX_WORD_LEN,
    parameter  int MAX_WORDS    = DEF_MAX_WORDS,
    localparam int LEN_W        = $clog2(MAX_WORD_LEN),
    localparam int WCNT_W       = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              EnCount,
    input  logic              Start,
    input  logic [LEN_W-1:0]  WordLenM1,
    input  logic [WCNT_W-1:0] NumWordsM1,
    input  logic              LsbFirst,
    input  logic              SCLKEdgeFlg,
    output logic [LEN_W-1:0]  BitIdx,
    output logic [WCNT_W-1:0] WordIdx,
    output logic              LastBit,
    output logic              WordFlg,
    output logic              FrameFlg,
    output logic              Busy
);

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_m1_q, len_m1_d;
    logic [WCNT_W-1:0]   num_m1_q, num_m1_d;
    logic                lsb_q, lsb_d;
    logic [WCNT_W-1:0]   word_idx_q, word_idx_d;
    logic                word_flg_q, word_flg_d;
    logic                frame_flg_q, frame_flg_d;

    logic                running;
    logic                start_ok;
    logic                abort;
    logic                edge_run;
    logic                bit_wrap;
    logic                last_word;
    logic [LEN_W-1:0]    bit_cnt;

    assign running   = (state_q == ST_RUN);
    assign start_ok  = ~running & Start & EnCount;
    assign abort     = running & ~EnCount;
    assign edge_run  = running & EnCount & SCLKEdgeFlg;
    assign last_word = (word_idx_q == num_m1_q);

    // Counter is held clear in IDLE so a new frame always begins at bit 0.
    spi_bit_cnt #(
        .LEN_W (LEN_W)
    ) u_bit_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (abort | ~running),
        .adv_i    (edge_run),
        .len_m1_i (len_m1_q),
        .cnt_o    (bit_cnt),
        .wrap_o   (bit_wrap)
    );

    always_comb begin
        state_d     = state_q;
        len_m1_d    = len_m1_q;
        num_m1_d    = num_m1_q;
        lsb_d       = lsb_q;
        word_idx_d  = word_idx_q;
        word_flg_d  = 1'b0;
        frame_flg_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                word_idx_d = '0;
                if (start_ok) begin
                    state_d  = ST_RUN;
                    len_m1_d = WordLenM1;
                    num_m1_d = NumWordsM1;
                    lsb_d    = LsbFirst;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d    = ST_IDLE;
                    word_idx_d = '0;
                end else if (bit_wrap) begin
                    word_flg_d = 1'b1;
                    if (last_word) begin
                        frame_flg_d = 1'b1;
                        state_d     = ST_IDLE;
                        word_idx_d  = '0;
                    end else begin
                        word_idx_d = word_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_m1_q    <= '0;
            num_m1_q    <= '0;
            lsb_q       <= 1'b0;
            word_idx_q  <= '0;
            word_flg_q  <= 1'b0;
            frame_flg_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_m1_q    <= len_m1_d;
            num_m1_q    <= num_m1_d;
            lsb_q       <= lsb_d;
            word_idx_q  <= word_idx_d;
            word_flg_q  <= word_flg_d;
            frame_flg_q <= frame_flg_d;
        end
    end

    assign Busy     = running;
    assign WordIdx  = word_idx_q;
    assign WordFlg  = word_flg_q;
    assign FrameFlg = frame_flg_q;
    assign LastBit  = running & (bit_cnt == len_m1_q);
    assign BitIdx   = ~running ? '0 : (lsb_q ? bit_cnt : len_m1_q - bit_cnt);

endmodule

// File: tb/tb_spi_frame_counter.sv
// Directed bench for spi_frame_counter with a frame-level reference model.
module tb_spi_frame_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       EnCount = 1'b0;
    logic       Start = 1'b0;
    logic [4:0] WordLenM1 = '0;
    logic [3:0] NumWordsM1 = '0;
    logic       LsbFirst = 1'b0;
    logic       SCLKEdgeFlg = 1'b0;
    logic [4:0] BitIdx;
    logic [3:0] WordIdx;
    logic       LastBit, WordFlg, FrameFlg, Busy;

    int n_vec  = 0;
    int n_fail = 0;

    // model state: counted edges in the current frame plus latched frame shape
    int  m_busy = 0, m_edges = 0, m_len = 1, m_words = 1, m_lsb = 0;
    int  m_wf = 0, m_ff = 0;

    spi_frame_counter dut (
        .clk(clk), .rst_n(rst_n), .EnCount(EnCount), .Start(Start),
        .WordLenM1(WordLenM1), .NumWordsM1(NumWordsM1), .LsbFirst(LsbFirst),
        .SCLKEdgeFlg(SCLKEdgeFlg), .BitIdx(BitIdx), .WordIdx(WordIdx),
        .LastBit(LastBit), .WordFlg(WordFlg), .FrameFlg(FrameFlg), .Busy(Busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_edges = 0; m_len = 1; m_words = 1; m_lsb = 0;
            m_wf = 0; m_ff = 0;
        end else begin
            m_wf = 0;
            m_ff = 0;
            if (m_busy == 0) begin
                if (Start && EnCount) begin
                    m_busy  = 1;
                    m_edges = 0;
                    m_len   = int'(WordLenM1) + 1;
                    m_words = int'(NumWordsM1) + 1;
                    m_lsb   = int'(LsbFirst);
                end
            end else if (!EnCount) begin
                m_busy  = 0;
                m_edges = 0;
            end else if (SCLKEdgeFlg) begin
                m_edges++;
                if (m_edges % m_len == 0) m_wf = 1;
                if (m_edges == m_len * m_words) begin
                    m_ff    = 1;
                    m_busy  = 0;
                    m_edges = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        int p, w;
        p = m_edges % m_len;
        w = m_edges / m_len;
        chk("Busy",     int'(Busy),     m_busy);
        chk("WordFlg",  int'(WordFlg),  m_wf);
        chk("FrameFlg", int'(FrameFlg), m_ff);
        chk("WordIdx",  int'(WordIdx),  m_busy ? w : 0);
        chk("BitIdx",   int'(BitIdx),   m_busy ? (m_lsb ? p : m_len - 1 - p) : 0);
        chk("LastBit",  int'(LastBit),  (m_busy && p == m_len - 1) ? 1 : 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int lenm1, input int numm1, input bit lsb);
        WordLenM1  = 5'(lenm1);
        NumWordsM1 = 4'(numm1);
        LsbFirst   = lsb;
        Start      = 1'b1;
        tick();
        Start      = 1'b0;
    endtask

    task automatic edges_gapped(input int n);
        for (int i = 0; i < n; i++) begin
            SCLKEdgeFlg = 1'b1;
            tick();
            SCLKEdgeFlg = 1'b0;
            if (i != n - 1) tick();
        end
    endtask

    task automatic edges_burst(input int n);
        SCLKEdgeFlg = 1'b1;
        repeat (n) tick();
        SCLKEdgeFlg = 1'b0;
    endtask

    initial begin
        #2;
        chk("reset_busy", int'(Busy), 0);
        chk("reset_flags", int'({WordFlg, FrameFlg}), 0);
        #20 rst_n = 1'b1;
        EnCount = 1'b1;
        tick();

        // 8-bit MSB-first, one word
        start_frame(7, 0, 1'b0);
        chk("t1_first_bitidx", int'(BitIdx), 7);
        chk("t1_busy", int'(Busy), 1);
        edges_gapped(8);
        chk("t1_wordflg", int'(WordFlg), 1);
        chk("t1_frameflg", int'(FrameFlg), 1);
        chk("t1_busy_drop", int'(Busy), 0);
        tick();
        chk("t1_flag_width", int'(WordFlg), 0);

        // 16-bit LSB-first, 3 words, edge every cycle
        start_frame(15, 2, 1'b1);
        chk("t2_first_bitidx", int'(BitIdx), 0);
        edges_burst(16);
        chk("t2_word0_flg", int'(WordFlg), 1);
        chk("t2_word0_noframe", int'(FrameFlg), 0);
        chk("t2_wordidx", int'(WordIdx), 1);
        edges_burst(32);
        chk("t2_frameflg", int'(FrameFlg), 1);
        tick();

        // 1-bit words, 4 words
        start_frame(0, 3, 1'b0);
        chk("t3_lastbit", int'(LastBit), 1);
        edges_burst(4);
        chk("t3_frameflg", int'(FrameFlg), 1);
        tick();

        // abort after 5 edges, then clean restart
        start_frame(7, 0, 1'b0);
        edges_gapped(5);
        EnCount = 1'b0;
        tick();
        chk("t4_abort_busy", int'(Busy), 0);
        chk("t4_abort_noflag", int'(WordFlg), 0);
        EnCount = 1'b1;
        tick();
        start_frame(7, 0, 1'b0);
        chk("t4_restart_bitidx", int'(BitIdx), 7);
        edges_gapped(8);
        chk("t4_frameflg", int'(FrameFlg), 1);
        tick();

        // Start with coincident edge, then ignored Start mid-frame
        WordLenM1 = 5'd7; NumWordsM1 = 4'd0; LsbFirst = 1'b0;
        Start = 1'b1; SCLKEdgeFlg = 1'b1;
        tick();
        Start = 1'b0; SCLKEdgeFlg = 1'b0;
        chk("t5_edge_uncounted", int'(BitIdx), 7);
        edges_gapped(2);
        WordLenM1 = 5'd3;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("t5_no_relatch", int'(BitIdx), 5);
        edges_gapped(5);
        chk("t5_not_done", int'(FrameFlg), 0);
        edges_gapped(1);
        chk("t5_frameflg", int'(FrameFlg), 1);
        tick();

        // async reset mid-word
        start_frame(7, 0, 1'b0);
        edges_gapped(3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", int'(Busy), 0);
        chk("t6_rst_bitidx", int'(BitIdx), 0);
        #3 rst_n = 1'b1;
        tick();
        edges_gapped(8);
        chk("t6_idle_noflag", int'(WordFlg), 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
